avalon_sdram_responder: RTL and testbench
=========================================

Name: avalon_sdram_responder

Overview:
- Avalon-MM slave (responder) that models the SDRAM window used by the multiply accelerator's master port.
- 16-bit word memory with a configurable fixed read latency and a bounded number of outstanding pipelined reads; asserts waitrequest on writes and on read back-pressure.
- Flags protocol errors and the accelerator's 16'hFFFF "done" write.
- Used as the simulation/bring-up target for the accelerator, and as a stand-in for the SDRAM controller in subsystem tests.

Parameters:
- BASE_ADDR, 32'hC0000000, byte address of word 0.
- DEPTH_WORDS, 81920, number of 16-bit words in the window.
- READ_LATENCY, 3, cycles from read acceptance to readdatavalid (>=1).
- MAX_PENDING, 2, maximum accepted-but-unreturned reads (1..READ_LATENCY).
- WRITE_WAIT, 1, cycles of waitrequest held on each write before it is accepted (0 = accept immediately).
- OOR_DATA, 16'hDEAD, read data returned for out-of-range addresses.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- chipselect  in  1  slave select.
- read_n  in  1  active-low read request.
- write_n  in  1  active-low write request.
- address  in  32  byte address; bit 0 ignored.
- byteenable  in  2  per-byte write enables (bit1 = [15:8]).
- writedata  in  16  write data.
- waitrequest  out  1  stall; request not accepted this cycle.
- readdatavalid  out  1  one-cycle strobe qualifying readdata.
- readdata  out  16  read return data.
- protocol_err  out  1  one-cycle pulse: read_n and write_n both low with chipselect high.
- done_seen  out  1  one-cycle pulse: accepted write of 16'hFFFF (both byte enables) to BASE_ADDR.
- oor_err  out  1  one-cycle pulse: accepted access outside the window.

Behaviour:
- Reset (async assert, sync release) clears all control state.
  - Forces waitrequest=0, readdatavalid=0, readdata=0, the three pulses to 0, pending=0, and the write FSM to W_IDLE.
  - Memory contents are untouched by reset and undefined at power-up.
  - Reads in flight at reset are discarded and never returned.
- Word index = (address - BASE_ADDR) >> 1. In range iff address >= BASE_ADDR and index < DEPTH_WORDS.
- Request decode (chipselect=1):
  - write_n=0 is a write. Write has priority: if read_n=0 in the same cycle, the read is ignored and protocol_err pulses.
  - read_n=0 with write_n=1 is a read.
  - chipselect=0: no request, waitrequest=0.
- Read path:
  - Read accepted in cycle n when requested and waitrequest=0.
  - Memory is sampled in cycle n, so writes accepted in cycle n-1 or earlier are visible.
  - readdatavalid is high exactly in cycle n+READ_LATENCY, with that read's data; returns stay strictly in order.
  - A master holding read_n low issues one read per unstalled cycle.
  - pending increments on accept and decrements on readdatavalid; both in one cycle leaves it unchanged.
  - Read waitrequest = (pending == MAX_PENDING) && !readdatavalid. The freed slot is reusable in the same cycle.
  - Out-of-range read returns OOR_DATA with normal latency and pulses oor_err in the accept cycle.
- Write path, FSM W_IDLE / W_WAIT:
  - W_IDLE + write request with WRITE_WAIT=0: accepted this cycle, waitrequest=0.
  - W_IDLE + write request with WRITE_WAIT>0: waitrequest=1, wait_cnt=1, go to W_WAIT.
  - W_WAIT: waitrequest stays 1 while wait_cnt < WRITE_WAIT, incrementing wait_cnt each cycle. When wait_cnt == WRITE_WAIT, waitrequest=0, the write is accepted, and the FSM returns to W_IDLE.
  - W_WAIT + write_n deasserted (master abandoned): return to W_IDLE with no memory update.
  - Address/data/byteenable are sampled in the accept cycle. Memory is updated per byteenable at the following edge.
  - byteenable=00 is accepted with no update.
  - Out-of-range write: accepted, dropped, oor_err pulses.
- Writes and in-flight reads proceed concurrently. Read returns already in the pipeline are unaffected by later writes.
- waitrequest is combinational from the request inputs and registered state. It is 0 when no request is present.
- Counters saturate at their defined maxima; address arithmetic is 32-bit unsigned with no wrap. An address below BASE_ADDR is out of range.

Test Plan:
- Reset, preload word 49 (addr C0000062) = 16'h1234. Single read at cycle 0 -> readdatavalid and readdata=16'h1234 in cycle 3 only; waitrequest=0 throughout.
- read_n held low, addresses C0000002, C0000004, C0000006 back-to-back, L=3, MAX_PENDING=2 -> accepts in cycles 0 and 1, waitrequest=1 in cycle 2, third accepted in cycle 3. Valids land in cycles 3, 4, 6, in order.
- Write 16'hABCD, byteenable=01, to C0000064 over existing 16'h5555 with WRITE_WAIT=1 -> waitrequest=1 for one cycle, then accepted. A subsequent read returns 16'h55CD.
- Write 16'hFFFF to C0000000 -> done_seen pulses exactly once, in the accept cycle. A following read of C0000000 returns 16'hFFFF.
- read_n and write_n both low -> protocol_err pulses and the write completes. No readdatavalid follows. Read of address C0000000 + 2*DEPTH_WORDS -> OOR_DATA after 3 cycles, oor_err pulses.
- Assert reset_n=0 asynchronously mid-clock with 2 reads pending -> readdatavalid and waitrequest drop immediately. No stale valid after release; memory contents are retained.

Source files
------------

// File: rtl/avalon_sdram_responder.sv
// Avalon-MM responder modelling the accelerator's SDRAM window: 16-bit words,
// fixed-latency pipelined reads, bounded outstanding reads, write wait states.
module avalon_sdram_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'hC000_0000,
  parameter int unsigned DEPTH_WORDS  = 81920,
  parameter int unsigned READ_LATENCY = 3,
  parameter int unsigned MAX_PENDING  = 2,
  parameter int unsigned WRITE_WAIT   = 1,
  parameter logic [15:0] OOR_DATA     = 16'hDEAD
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] address,
  input  logic [1:0]  byteenable,
  input  logic [15:0] writedata,
  output logic        waitrequest,
  output logic        readdatavalid,
  output logic [15:0] readdata,
  output logic        protocol_err,
  output logic        done_seen,
  output logic        oor_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned PW = $clog2(MAX_PENDING + 1);
  localparam int unsigned WW = (WRITE_WAIT > 0) ? $clog2(WRITE_WAIT + 1) : 1;
  localparam int unsigned L  = READ_LATENCY;

  typedef enum logic {W_IDLE, W_WAIT} wstate_t;

  logic [15:0]   mem [DEPTH_WORDS];
  logic [31:0]   offset;
  logic [30:0]   word;
  logic          in_range;
  logic          wr_req;
  logic          rd_req;
  logic          wr_wait;
  logic          rd_wait;
  logic          wr_acc;
  logic          rd_acc;
  logic [15:0]   rd_data;
  wstate_t       wstate;
  logic [WW-1:0] wait_cnt;
  logic [PW-1:0] pending;
  logic [L-1:0]  pipe_vld;
  logic [15:0]   pipe_dat [L];
  logic          unused_bits;

  // Window decode: bit 0 of the byte address selects nothing.
  assign offset      = address - BASE_ADDR;
  assign word        = offset[31:1];
  assign in_range    = (address >= BASE_ADDR) && ({1'b0, word} < DEPTH_WORDS);
  assign unused_bits = offset[0];

  // Write wins over a simultaneous read; the read is dropped.
  assign wr_req = reset_n & chipselect & ~write_n;
  assign rd_req = reset_n & chipselect & write_n & ~read_n;

  always_comb begin : write_wait_decode
    wr_wait = 1'b0;
    if (wr_req) begin
      if (wstate == W_IDLE) wr_wait = (WRITE_WAIT != 0);
      else                  wr_wait = (wait_cnt < WW'(WRITE_WAIT));
    end
  end

  // A return leaving this cycle frees its slot for a same-cycle accept.
  assign rd_wait = (pending == PW'(MAX_PENDING)) && !readdatavalid;

  assign wr_acc  = wr_req & ~wr_wait;
  assign rd_acc  = rd_req & ~rd_wait;
  assign rd_data = in_range ? mem[word[AW-1:0]] : OOR_DATA;

  assign waitrequest  = (wr_req & wr_wait) | (rd_req & rd_wait);
  assign protocol_err = reset_n & chipselect & ~read_n & ~write_n;
  assign oor_err      = (wr_acc | rd_acc) & ~in_range;
  assign done_seen    = wr_acc & in_range & (word == '0) &
                        (byteenable == 2'b11) & (writedata == 16'hFFFF);

  always_ff @(posedge clk or negedge reset_n) begin : write_fsm
    if (!reset_n) begin
      wstate   <= W_IDLE;
      wait_cnt <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (wr_req && wr_wait) begin
            wstate   <= W_WAIT;
            wait_cnt <= WW'(1);
          end
        end
        W_WAIT: begin
          if (!wr_req || !wr_wait) begin
            wstate   <= W_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: begin
          wstate   <= W_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : pending_count
    if (!reset_n) begin
      pending <= '0;
    end else if (rd_acc && !readdatavalid) begin
      if (pending != PW'(MAX_PENDING)) pending <= pending + PW'(1);
    end else if (!rd_acc && readdatavalid) begin
      if (pending != '0) pending <= pending - PW'(1);
    end
  end

  // Data is captured at accept, so later writes never alter queued returns.
  always_ff @(posedge clk or negedge reset_n) begin : read_pipe
    if (!reset_n) begin
      pipe_vld <= '0;
      for (int k = 0; k < L; k++) pipe_dat[k] <= '0;
    end else begin
      pipe_vld[0] <= rd_acc;
      pipe_dat[0] <= rd_acc ? rd_data : 16'h0000;
      for (int k = 1; k < L; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_dat[k] <= pipe_dat[k-1];
      end
    end
  end

  assign readdatavalid = pipe_vld[L-1];
  assign readdata      = pipe_dat[L-1];

  // Storage is not reset; contents survive reset_n.
  always_ff @(posedge clk) begin : mem_write
    if (wr_acc && in_range) begin
      if (byteenable[0]) mem[word[AW-1:0]][7:0]  <= writedata[7:0];
      if (byteenable[1]) mem[word[AW-1:0]][15:8] <= writedata[15:8];
    end
  end

endmodule

// File: tb/tb_avalon_sdram_responder.sv
// Scoreboard bench for avalon_sdram_responder: directed scenarios plus random
// traffic, checked against a transaction-level model of the SDRAM window.
module tb_avalon_sdram_responder;

  localparam logic [31:0] BASE  = 32'hC000_0000;
  localparam int unsigned DEPTH = 81920;
  localparam int unsigned LAT   = 3;
  localparam int unsigned MAXP  = 2;
  localparam int unsigned WWAIT = 1;
  localparam logic [15:0] OOR   = 16'hDEAD;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] address;
  logic [1:0]  byteenable;
  logic [15:0] writedata;
  logic        waitrequest;
  logic        readdatavalid;
  logic [15:0] readdata;
  logic        protocol_err;
  logic        done_seen;
  logic        oor_err;

  always #5 clk = ~clk;

  avalon_sdram_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT),
    .MAX_PENDING(MAXP), .WRITE_WAIT(WWAIT), .OOR_DATA(OOR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .read_n(read_n),
    .write_n(write_n), .address(address), .byteenable(byteenable),
    .writedata(writedata), .waitrequest(waitrequest),
    .readdatavalid(readdatavalid), .readdata(readdata),
    .protocol_err(protocol_err), .done_seen(done_seen), .oor_err(oor_err)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        known;
    logic [31:0] due;
  } exp_t;

  exp_t        sb[$];
  int unsigned ret_due[$];
  logic [15:0] mdl [int unsigned];
  int unsigned cyc = 0;
  int unsigned wr_held = 0;
  bit          exp_wait, exp_perr, exp_oor, exp_done;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] pool [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Output monitor: per-cycle strobes and in-order read returns.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   exp_v;
    if (reset_n) begin
      chk("waitrequest", 32'(waitrequest), 32'(exp_wait));
      chk("protocol_err", 32'(protocol_err), 32'(exp_perr));
      chk("oor_err", 32'(oor_err), 32'(exp_oor));
      chk("done_seen", 32'(done_seen), 32'(exp_done));
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      chk("readdatavalid", 32'(readdatavalid), 32'(exp_v));
      if (exp_v) begin
        e = sb.pop_front();
        if (e.known) chk("readdata", 32'(readdata), 32'(e.data));
      end
      while (sb.size() > 0 && sb[0].due <= cyc) sb.delete(0);
    end
  end

  // One bus cycle: drive inputs, predict the responder's behaviour, advance.
  task automatic step(input bit cs, input bit rn, input bit wn, input logic [31:0] a,
                      input logic [1:0] be, input logic [15:0] wd, output bit acc);
    bit              wr, rd, wt, inr, known;
    longint unsigned a64;
    int unsigned     idx;
    logic [15:0]     w;
    exp_t            e;
    chipselect = cs; read_n = rn; write_n = wn;
    address = a; byteenable = be; writedata = wd;
    wr  = cs && !wn;
    rd  = cs && wn && !rn;
    a64 = 64'(a);
    inr = (a64 >= 64'(BASE)) && (((a64 - 64'(BASE)) / 2) < 64'(DEPTH));
    idx = inr ? 32'((a64 - 64'(BASE)) / 2) : 0;
    while (ret_due.size() > 0 && ret_due[0] <= cyc) ret_due.delete(0);
    wt = 1'b0;
    acc = 1'b0;
    if (wr) begin
      if (wr_held < WWAIT) begin wt = 1'b1; wr_held++; end
      else begin acc = 1'b1; wr_held = 0; end
    end else begin
      wr_held = 0;
    end
    if (rd) begin
      if (ret_due.size() >= MAXP) wt = 1'b1;
      else acc = 1'b1;
    end
    exp_wait = wt;
    exp_perr = cs && !rn && !wn;
    exp_oor  = acc && !inr;
    exp_done = wr && acc && inr && idx == 0 && be == 2'b11 && wd == 16'hFFFF;
    if (rd && acc) begin
      ret_due.push_back(cyc + LAT);
      known  = inr ? mdl.exists(idx) : 1'b1;
      e.data  = !inr ? OOR : (known ? mdl[idx] : 16'h0000);
      e.known = known;
      e.due   = cyc + LAT;
      sb.push_back(e);
    end
    if (wr && acc && inr) begin
      if (mdl.exists(idx)) begin
        w = mdl[idx];
        if (be[0]) w[7:0]  = wd[7:0];
        if (be[1]) w[15:8] = wd[15:8];
        mdl[idx] = w;
      end else if (be == 2'b11) begin
        mdl[idx] = wd;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Master holds a request until the model says it is accepted.
  task automatic issue(input bit rn, input bit wn, input logic [31:0] a,
                       input logic [1:0] be, input logic [15:0] wd);
    bit acc;
    int tries = 0;
    do begin
      step(1'b1, rn, wn, a, be, wd, acc);
      tries++;
    end while (!acc && tries < 16);
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout at cycle %0d: got no accept, expected accept", cyc);
    end
  endtask

  task automatic do_read(input logic [31:0] a);
    issue(1'b0, 1'b1, a, 2'b00, 16'h0000);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [1:0] be, input logic [15:0] wd);
    issue(1'b1, 1'b0, a, be, wd);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 32'h0, 2'b00, 16'h0, acc);
  endtask

  task automatic model_reset();
    sb.delete();
    ret_due.delete();
    wr_held  = 0;
    exp_wait = 1'b0; exp_perr = 1'b0; exp_oor = 1'b0; exp_done = 1'b0;
  endtask

  initial begin : driver
    bit acc;
    int op;
    logic [31:0] a;
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    address = '0; byteenable = '0; writedata = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_waitrequest", 32'(waitrequest), 32'(0));
    chk("reset_readdatavalid", 32'(readdatavalid), 32'(0));
    chk("reset_readdata", 32'(readdata), 32'(0));
    chk("reset_pulses", 32'({protocol_err, done_seen, oor_err}), 32'(0));
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // Single read of a preloaded word.
    do_write(BASE + 32'h62, 2'b11, 16'h1234);
    do_read(BASE + 32'h62);
    idle(LAT + 1);

    // Back-to-back reads exercising the outstanding-read limit.
    do_write(BASE + 32'h2, 2'b11, 16'h0102);
    do_write(BASE + 32'h4, 2'b11, 16'h0304);
    do_write(BASE + 32'h6, 2'b11, 16'h0506);
    do_read(BASE + 32'h2);
    do_read(BASE + 32'h4);
    do_read(BASE + 32'h6);
    idle(LAT + 2);

    // Low-byte-only write merges with existing contents.
    do_write(BASE + 32'h64, 2'b11, 16'h5555);
    do_write(BASE + 32'h64, 2'b01, 16'hABCD);
    do_write(BASE + 32'h64, 2'b00, 16'h9999);
    do_read(BASE + 32'h64);
    idle(LAT + 1);

    // Done marker write and readback.
    do_write(BASE, 2'b11, 16'hFFFF);
    do_read(BASE);
    idle(LAT + 1);

    // Read/write collision, then out-of-range accesses on both sides.
    issue(1'b0, 1'b0, BASE + 32'h66, 2'b11, 16'h0F0F);
    idle(LAT + 1);
    do_read(BASE + 32'h66);
    do_read(BASE + 32'(2 * DEPTH));
    do_read(BASE - 32'h2);
    do_write(BASE + 32'(2 * DEPTH), 2'b11, 16'h7777);
    do_read(BASE + 32'(2 * DEPTH - 2));
    idle(LAT + 1);

    // Random traffic over a pool straddling both ends of the window.
    for (int i = 0; i < 16; i++) begin
      pool[i] = BASE + 32'(2 * ((i < 8) ? i : (DEPTH - 16 + i)));
      do_write(pool[i], 2'b11, 16'($urandom));
    end
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 9));
      a  = pool[$urandom_range(0, 15)];
      case (op)
        0, 1, 2, 3: do_read(a);
        4, 5, 6:    do_write(a, 2'($urandom_range(0, 3)), 16'($urandom));
        7: step(1'b0, 1'($urandom), 1'($urandom), a, 2'b11, 16'($urandom), acc);
        8: begin
          step(1'b1, 1'b1, 1'b0, a, 2'b11, 16'($urandom), acc);
          step(1'b0, 1'b1, 1'b1, a, 2'b00, 16'h0, acc);
        end
        default: begin
          a = ($urandom_range(0, 1) == 0) ? BASE + 32'(2 * DEPTH) + 32'(2 * $urandom_range(0, 7))
                                          : BASE - 32'(2 * $urandom_range(1, 8));
          if ($urandom_range(0, 1) == 0) do_read(a);
          else if ($urandom_range(0, 1) == 0) do_write(a, 2'b11, 16'($urandom));
          else issue(1'b0, 1'b0, pool[$urandom_range(0, 15)], 2'b11, 16'($urandom));
        end
      endcase
    end
    idle(LAT + 2);

    // Asynchronous reset mid-cycle with two reads outstanding.
    do_read(BASE + 32'h2);
    do_read(BASE + 32'h4);
    chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1; address = BASE + 32'h6;
    #1 chk("pre_reset_waitrequest", 32'(waitrequest), 32'(1));
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_waitrequest", 32'(waitrequest), 32'(0));
    chk("async_reset_readdatavalid", 32'(readdatavalid), 32'(0));
    chk("async_reset_readdata", 32'(readdata), 32'(0));
    chipselect = 1'b0; read_n = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    idle(LAT + 3);
    do_read(BASE + 32'h62);
    do_read(BASE + 32'h64);
    do_read(BASE);
    idle(LAT + 2);

    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
